apb_regfile_slave: RTL and testbench

//  APB3 completer sitting directly downstream of apb_master: consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA,

---
 rtl/apb_regfile_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB3 completer holding a bank of NUM_REGS word registers starting at
//   BASE_ADDR. Each transfer is stretched by WAIT_CYCLES extra access-phase
//   cycles before PREADY. Completed in-range writes are announced to fabric
//   logic through a one-cycle strobe carrying the register index, and the
//   whole bank is exported as a flat vector.
//
// Ports
//   PCLK        in   clock, all logic on the rising edge
//   PRESET      in   synchronous reset, active-high
//   PSEL        in   APB select
//   PENABLE     in   APB enable (access phase)
//   PADDR       in   byte address [ADDR_W]
//   PWRITE      in   1 = write, 0 = read
//   PWDATA      in   write data [DATA_W]
//   PRDATA      out  read data, meaningful only while PREADY=1
//   PREADY      out  transfer completion (registered, one cycle wide)
//   PSLVERR     out  error response, meaningful only while PREADY=1
//   regs_o      out  register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse_o  out  one-cycle pulse on a committed in-range write
//   wr_idx_o    out  index of the committed write, valid with wr_pulse_o
//
// Build option
//   APB_SLVERR_EN  when defined, PSLVERR reports out-of-window or misaligned
//                  accesses on completion; when undefined PSLVERR is tied 0
//                  and such accesses are silently dropped / read as zero.
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hA000,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_CYCLES = 0,
  localparam int               IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic                       PWRITE,
  input  logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse_o,
  output logic [IDX_W-1:0]           wr_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Window bounds carry one extra bit so a window ending exactly at the top
  // of the address space cannot wrap around.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(4 * NUM_REGS);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hit_q, hit_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                commit_wr;
`ifdef APB_SLVERR_EN
  logic                pslverr_q, pslverr_d;
`endif

  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                addr_hit;
  logic [IDX_W-1:0]    addr_idx;

  // Address decode, used only when the setup phase is latched.
  assign addr_hit = ({1'b0, PADDR} >= WIN_LO) &&
                    ({1'b0, PADDR} <  WIN_HI) &&
                    (PADDR[1:0] == 2'b00);
  assign addr_idx = IDX_W'((PADDR - BASE_ADDR) >> 2);

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    commit_wr  = 1'b0;
`ifdef APB_SLVERR_EN
    pslverr_d  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray PENABLE
        // without a preceding setup is ignored.
        if (PSEL && !PENABLE) begin
          idx_d   = addr_idx;
          hit_d   = addr_hit;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = S_IDLE;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            // Completion uses only the values latched at setup.
            pready_d = 1'b1;
            state_d  = S_DONE;
            if (wr_q) begin
              if (hit_q) begin
                commit_wr  = 1'b1;
                wr_pulse_d = 1'b1;
                wr_idx_d   = idx_q;
              end
            end else if (hit_q) begin
              prdata_d = regs_q[idx_q];
            end
`ifdef APB_SLVERR_EN
            pslverr_d = ~hit_q;
`endif
          end
        end
      end

      S_DONE: begin
        // PREADY/PRDATA/PSLVERR fall back to zero through the defaults.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Transfer context and response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

`ifdef APB_SLVERR_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= pslverr_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Register bank
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_wr) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_idx_o   = wr_idx_q;
`ifdef APB_SLVERR_EN
  assign PSLVERR    = pslverr_q;
`else
  assign PSLVERR    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances with WAIT_CYCLES 0, 3 and 2,
// each on its own APB bus, driven by a transfer-level master and compared
// every cycle against a register-array model of the completer.
module tb_apb_regfile_slave;
  localparam int          ND   = 3;
  localparam int          NR   = 16;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'hA000;

  logic clk = 1'b0;
  logic preset;
  always #5 clk = ~clk;

  logic           psel    [ND];
  logic           penable [ND];
  logic           pwrite  [ND];
  logic [31:0]    paddr   [ND];
  logic [31:0]    pwdata  [ND];
  logic [31:0]    prdata  [ND];
  logic           pready  [ND];
  logic           pslverr [ND];
  logic           wr_pulse[ND];
  logic [3:0]     wr_idx  [ND];
  logic [NR*DW-1:0] regs  [ND];

  apb_regfile_slave #(.ADDR_W(32), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .regs_o(regs[0]), .wr_pulse_o(wr_pulse[0]), .wr_idx_o(wr_idx[0]));

  apb_regfile_slave #(.ADDR_W(32), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .regs_o(regs[1]), .wr_pulse_o(wr_pulse[1]), .wr_idx_o(wr_idx[1]));

  apb_regfile_slave #(.ADDR_W(32), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(2)) u_w2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]), .PADDR(paddr[2]),
    .PWRITE(pwrite[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .regs_o(regs[2]), .wr_pulse_o(wr_pulse[2]), .wr_idx_o(wr_idx[2]));

  // Model state: register contents and what each output must show this cycle.
  logic [31:0] mem [ND][NR];
  logic        exp_ready[ND];
  logic        exp_pulse[ND];
  logic        exp_err  [ND];
  logic        exp_rd   [ND];
  logic [3:0]  exp_idx  [ND];
  logic [31:0] exp_rdata[ND];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  function automatic int wc(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NR)) && (a[1:0] == 2'b00);
  endfunction

  task automatic chk32(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input int d, input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin : cmp
    logic [NR*DW-1:0] ef;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        for (int i = 0; i < NR; i++) ef[i*DW +: DW] = mem[d][i];
        chk32(d, "PREADY", 32'(pready[d]), 32'(exp_ready[d]));
        chk32(d, "wr_pulse_o", 32'(wr_pulse[d]), 32'(exp_pulse[d]));
        if (exp_ready[d]) chk32(d, "PSLVERR", 32'(pslverr[d]), 32'(exp_err[d]));
        if (exp_ready[d] && exp_rd[d]) chk32(d, "PRDATA", prdata[d], exp_rdata[d]);
        if (exp_pulse[d]) chk32(d, "wr_idx_o", 32'(wr_idx[d]), 32'(exp_idx[d]));
        chkv(d, "regs_o", regs[d], ef);
      end
    end
  end

  // Advance one cycle; the model expects quiet outputs unless told otherwise.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_ready[d] = 1'b0;
      exp_pulse[d] = 1'b0;
      exp_err[d]   = 1'b0;
      exp_rd[d]    = 1'b0;
      exp_idx[d]   = 4'd0;
      exp_rdata[d] = 32'h0;
    end
  endtask

  task automatic idle(input int d);
    cyc();
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One APB transfer. The access phase lasts exactly as long as the model
  // says the completer needs (WAIT_CYCLES+2 cycles), so a mistimed PREADY
  // shows up as a mismatch rather than a hang. Address and write data are
  // scrambled during the access phase to prove they are not re-sampled.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit abort, output logic [31:0] obs_rd, output int obs_k,
                      output logic obs_pulse, output logic [3:0] obs_idx);
    bit         hit;
    logic [3:0] idx;
    int         w;
    hit = m_hit(addr);
    idx = 4'((addr - BASE) >> 2);
    w   = wc(d);
    obs_rd = 32'h0; obs_k = 0; obs_pulse = 1'b0; obs_idx = 4'd0;
    cyc();
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr; pwdata[d] = data;
    if (abort) begin
      cyc();
      psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = $urandom;
      return;
    end
    for (int k = 1; k <= w + 2; k++) begin
      cyc();
      penable[d] = 1'b1;
      paddr[d]   = $urandom;
      pwdata[d]  = $urandom;
      if (k == w + 2) begin
        exp_ready[d] = 1'b1;
`ifdef APB_SLVERR_EN
        exp_err[d]   = !hit;
`endif
        exp_rd[d]    = !wr;
        exp_rdata[d] = (!wr && hit) ? mem[d][idx] : 32'h0;
        if (wr && hit) begin
          mem[d][idx]  = data;
          exp_pulse[d] = 1'b1;
          exp_idx[d]   = idx;
        end
      end
      @(negedge clk);
      if (pready[d] === 1'b1 && obs_k == 0) begin
        obs_k     = k;
        obs_rd    = prdata[d];
        obs_pulse = wr_pulse[d];
        obs_idx   = wr_idx[d];
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    int          k;
    logic        pl;
    logic [3:0]  ix;
    int          r;
    logic [31:0] a;

    preset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 32'h0; pwdata[d] = 32'h0;
      exp_ready[d] = 1'b0; exp_pulse[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 1'b0;
      exp_idx[d] = 4'd0; exp_rdata[d] = 32'h0;
      for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
    end

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    preset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk32(d, "rst_PREADY", 32'(pready[d]), 32'h0);
      chk32(d, "rst_PRDATA", prdata[d], 32'h0);
      chk32(d, "rst_PSLVERR", 32'(pslverr[d]), 32'h0);
      chk32(d, "rst_wr_pulse", 32'(wr_pulse[d]), 32'h0);
      chkv(d, "rst_regs", regs[d], '0);
    end

    // Zero wait states: write then read register 1.
    xfer(0, 1'b1, 32'hA004, 32'hDEADBEEF, 1'b0, rd, k, pl, ix);
    chk32(0, "w0_wr_ready_cycle", 32'(k), 32'd2);
    chk32(0, "w0_wr_pulse", 32'(pl), 32'h1);
    chk32(0, "w0_wr_idx", 32'(ix), 32'h1);
    chk32(0, "w0_reg1", regs[0][63:32], 32'hDEADBEEF);
    xfer(0, 1'b0, 32'hA004, 32'h0, 1'b0, rd, k, pl, ix);
    chk32(0, "w0_rd_ready_cycle", 32'(k), 32'd2);
    chk32(0, "w0_rd_data", rd, 32'hDEADBEEF);
    idle(0);

    // Three wait states: PREADY first seen in the fifth access cycle.
    xfer(1, 1'b0, 32'hA000, 32'h0, 1'b0, rd, k, pl, ix);
    chk32(1, "w3_rd_ready_cycle", 32'(k), 32'd5);
    chk32(1, "w3_rd_data", rd, 32'h0);
    idle(1);

    // Misses: past the window, misaligned, and below the window.
    xfer(0, 1'b1, 32'hA040, 32'h11111111, 1'b0, rd, k, pl, ix);
    chk32(0, "miss_hi_pulse", 32'(pl), 32'h0);
    chk32(0, "miss_hi_ready_cycle", 32'(k), 32'd2);
    xfer(0, 1'b1, 32'hA002, 32'h22222222, 1'b0, rd, k, pl, ix);
    chk32(0, "miss_mis_pulse", 32'(pl), 32'h0);
    xfer(0, 1'b1, 32'h9FFC, 32'h33333333, 1'b0, rd, k, pl, ix);
    chk32(0, "miss_lo_pulse", 32'(pl), 32'h0);
    xfer(0, 1'b0, 32'hA040, 32'h0, 1'b0, rd, k, pl, ix);
    chk32(0, "miss_rd_data", rd, 32'h0);
    chk32(0, "miss_reg1_kept", regs[0][63:32], 32'hDEADBEEF);

    // Last register in the window.
    xfer(0, 1'b1, 32'hA03C, 32'h0F0F1234, 1'b0, rd, k, pl, ix);
    chk32(0, "top_wr_idx", 32'(ix), 32'd15);
    chk32(0, "top_reg15", regs[0][511:480], 32'h0F0F1234);
    idle(0);

    // PENABLE without a setup phase must not start a transfer.
    cyc();
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'hA00C; pwrite[0] = 1'b1; pwdata[0] = 32'h77777777;
    cyc();
    cyc();
    idle(0);
    chk32(0, "stray_enable_reg3", regs[0][127:96], 32'h0);

    // Abort right after setup with two wait states.
    xfer(2, 1'b1, 32'hA00C, 32'hCAFEF00D, 1'b1, rd, k, pl, ix);
    idle(2);
    idle(2);
    chk32(2, "abort_reg3", regs[2][127:96], 32'h0);

    // Back-to-back write then read with no idle cycle between.
    xfer(0, 1'b1, 32'hA008, 32'h12345678, 1'b0, rd, k, pl, ix);
    xfer(0, 1'b0, 32'hA008, 32'h0, 1'b0, rd, k, pl, ix);
    chk32(0, "b2b_rd_data", rd, 32'h12345678);
    idle(0);

    // Randomized traffic on every instance.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 60; n++) begin
        r = int'($urandom_range(0, 9));
        if (r <= 6)      a = BASE + 32'(4 * $urandom_range(0, NR - 1));
        else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(1, 3));
        else if (r == 8) begin
          case ($urandom_range(0, 2))
            0:       a = BASE - 32'd4;
            1:       a = BASE + 32'(4 * NR);
            default: a = BASE + 32'(4 * NR) + 32'(4 * $urandom_range(0, 255));
          endcase
        end else         a = $urandom;
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) == 0), rd, k, pl, ix);
        repeat ($urandom_range(0, 2)) idle(d);
      end
      idle(d);
    end

    // Reset in the middle of a stretched write: nothing commits and the
    // whole bank returns to zero.
    xfer(1, 1'b1, 32'hA008, 32'h0BADF00D, 1'b0, rd, k, pl, ix);
    idle(1);
    cyc();
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'hA008; pwrite[1] = 1'b1; pwdata[1] = 32'h5A5A5A5A;
    cyc();
    penable[1] = 1'b1;
    cyc();
    preset = 1'b1;
    cyc();
    preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
    @(negedge clk);
    chk32(1, "midrst_reg2", regs[1][95:64], 32'h0);
    chk32(1, "midrst_PREADY", 32'(pready[1]), 32'h0);
    xfer(1, 1'b0, 32'hA008, 32'h0, 1'b0, rd, k, pl, ix);
    chk32(1, "midrst_rd_data", rd, 32'h0);
    chk32(1, "midrst_rd_ready_cycle", 32'(k), 32'd5);
    idle(1);
    repeat (3) idle(0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
